miss_refill_controller: RTL and testbench
=========================================

MISS_REFILL_CONTROLLER -- requirements
Module: miss_refill_controller

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 16, word address width.
- INDEX_BITS, 6, cache set-index width.
- MEM_DATA_WIDTH, 320, refill block width.
- WORD_WIDTH, 20, instruction word width.
- B_OFFSET_BITS, 4, block word-offset width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- i_clk  in  1  single clock; all state changes on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_miss_valid  in  1  lookup stage reports a miss.
- i_miss_addr  in  ADDR_WIDTH  missed word address.
- o_miss_ready  out  1  controller can accept a miss.
- o_mem_req_valid  out  1  block read request to memory.
- o_mem_req_addr  out  ADDR_WIDTH  block-aligned request address.
- i_mem_req_ready  in  1  memory accepts the request.
- i_mem_rsp_valid  in  1  block data valid; single beat, no backpressure.
- i_mem_rsp_data  in  MEM_DATA_WIDTH  refill block, word 0 in bits [19:0].
- o_fill_valid  out  1  one-cycle write strobe to data/tag arrays.
- o_fill_index  out  INDEX_BITS  set index to write.
- o_fill_tag  out  ADDR_WIDTH-INDEX_BITS-B_OFFSET_BITS  tag to write.
- o_fill_data  out  MEM_DATA_WIDTH  block to write.
- o_word_valid  out  1  missed word available to core.
- o_word  out  WORD_WIDTH  missed (critical) word.
- i_word_ready  in  1  core consumes the word.
- i_flush  in  1  abort the outstanding miss (branch redirect).
- o_busy  out  1  high in every state except IDLE.

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, FILL, DELIVER, DRAIN.
REQ-004 IDLE: o_miss_ready=1; on i_miss_valid, latch i_miss_addr and go to REQ the next cycle. i_flush in IDLE has no effect.
REQ-005 REQ: o_mem_req_valid=1 and o_mem_req_addr={latched_addr[ADDR_WIDTH-1:4],4'b0}, held stable until i_mem_req_ready=1, then go to WAIT.
REQ-006 WAIT: on i_mem_rsp_valid, register i_mem_rsp_data and go to FILL; minimum miss-to-fill latency is 3 cycles (IDLE->REQ->WAIT->FILL) with same-cycle ready/response.
REQ-007 FILL (exactly one cycle):
- o_fill_valid=1, with o_fill_index=addr[INDEX_BITS+3:4], o_fill_tag=addr[ADDR_WIDTH-1:INDEX_BITS+4], o_fill_data=registered block.
- o_word_valid=1 in the same cycle.
- Next state IDLE if i_word_ready=1, else DELIVER.
REQ-008 o_word SHALL be bits [20*k+19:20*k] of the registered block, where k=addr[3:0]; k=15 selects [319:300].
REQ-009 DELIVER: o_word_valid=1, o_word stable; go to IDLE on i_word_ready.
REQ-010 Flush behaviour:
- REQ, no handshake this cycle -> IDLE.
- REQ with request handshake in the same cycle -> DRAIN.
- WAIT -> DRAIN; if i_mem_rsp_valid is high in the same cycle, the response is discarded and the next state is IDLE.
REQ-011 DRAIN: no fill and no word; the next i_mem_rsp_valid is discarded and the FSM returns to IDLE. o_miss_ready=0 throughout DRAIN.
REQ-012 Flush in FILL: fill completes, o_word_valid is dropped, next state IDLE. Flush in DELIVER: next state IDLE with no word handshake.
REQ-013 Only one miss SHALL be outstanding. i_miss_valid outside IDLE is ignored.
REQ-014 o_fill_valid SHALL never be asserted for a flushed miss, except under REQ-012.

Reset
REQ-015 Asserting i_rst SHALL immediately force IDLE, with o_mem_req_valid, o_fill_valid, o_word_valid and o_busy at 0 and o_miss_ready at 1. Data registers reset to 0.
REQ-016 Reset mid-miss SHALL abandon the miss with no drain. A late memory response arriving in IDLE is ignored.

Structure
REQ-017 ADDR_WIDTH, INDEX_BITS, MEM_DATA_WIDTH, WORD_WIDTH, B_OFFSET_BITS and the FSM state encoding SHALL reside in a shared icache package.
REQ-018 Word selection SHALL instantiate missed_word_driver, with i_valid tied to the FILL/DELIVER condition.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Miss at addr 0x1A37, ready and response immediate, i_word_ready=1: o_mem_req_addr=0x1A30; fill 3 cycles after miss with index=0x23, tag=0x06; o_word=block[159:140].
- Miss at offset 15, i_word_ready low 4 cycles: o_fill_valid high 1 cycle only; o_word=block[319:300] held stable 5 cycles.
- i_mem_req_ready low 5 cycles: addr and valid stable throughout; flush on cycle 3 -> IDLE, no request accepted, no fill.
- Flush in WAIT, response 6 cycles later: no o_fill_valid, no o_word_valid; o_miss_ready returns only after the response.
- Flush coincident with i_mem_rsp_valid in WAIT: response dropped, IDLE next cycle.
- i_rst asserted in DELIVER: outputs clear asynchronously; a new miss is accepted on the first cycle after deassertion.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: geometry and refill FSM encoding.
package icache_pkg;

  localparam int ADDR_WIDTH     = 16;
  localparam int INDEX_BITS     = 6;
  localparam int MEM_DATA_WIDTH = 320;
  localparam int WORD_WIDTH     = 20;
  localparam int B_OFFSET_BITS  = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_FILL    = 3'd3,
    S_DELIVER = 3'd4,
    S_DRAIN   = 3'd5
  } refill_state_e;

endpackage

// File: rtl/missed_word_driver.sv
// Selects the critical word out of a refill block by word offset.
module missed_word_driver #(
  parameter int MEM_DATA_WIDTH = 320,
  parameter int WORD_WIDTH     = 20,
  parameter int B_OFFSET_BITS  = 4
) (
  input  logic                      i_valid,
  input  logic [MEM_DATA_WIDTH-1:0] i_block,
  input  logic [B_OFFSET_BITS-1:0]  i_offset,
  output logic                      o_valid,
  output logic [WORD_WIDTH-1:0]     o_word
);

  localparam int NWORDS = MEM_DATA_WIDTH / WORD_WIDTH;

  logic [NWORDS-1:0][WORD_WIDTH-1:0] words;

  // Word 0 lives in the least-significant slice of the block.
  for (genvar w = 0; w < NWORDS; w++) begin : g_word
    assign words[w] = i_block[w*WORD_WIDTH +: WORD_WIDTH];
  end

  // Word mux; data is driven regardless of valid so it stays stable while held.
  always_comb begin
    o_valid = i_valid;
    o_word  = words[i_offset];
  end

endmodule

// File: rtl/miss_refill_controller.sv
// Single-outstanding I-cache miss refill: request block, fill arrays, hand the
// critical word to the core, and absorb flushes without corrupting the cache.
module miss_refill_controller #(
  parameter int ADDR_WIDTH     = icache_pkg::ADDR_WIDTH,
  parameter int INDEX_BITS     = icache_pkg::INDEX_BITS,
  parameter int MEM_DATA_WIDTH = icache_pkg::MEM_DATA_WIDTH,
  parameter int WORD_WIDTH     = icache_pkg::WORD_WIDTH,
  parameter int B_OFFSET_BITS  = icache_pkg::B_OFFSET_BITS
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_miss_valid,
  input  logic [ADDR_WIDTH-1:0]                       i_miss_addr,
  output logic                                        o_miss_ready,
  output logic                                        o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]                       o_mem_req_addr,
  input  logic                                        i_mem_req_ready,
  input  logic                                        i_mem_rsp_valid,
  input  logic [MEM_DATA_WIDTH-1:0]                   i_mem_rsp_data,
  output logic                                        o_fill_valid,
  output logic [INDEX_BITS-1:0]                       o_fill_index,
  output logic [ADDR_WIDTH-INDEX_BITS-B_OFFSET_BITS-1:0] o_fill_tag,
  output logic [MEM_DATA_WIDTH-1:0]                   o_fill_data,
  output logic                                        o_word_valid,
  output logic [WORD_WIDTH-1:0]                       o_word,
  input  logic                                        i_word_ready,
  input  logic                                        i_flush,
  output logic                                        o_busy
);

  import icache_pkg::*;

  refill_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [MEM_DATA_WIDTH-1:0]   block_q, block_d;
  logic                        word_en;

  // State and data registers; reset abandons any miss in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      block_q <= block_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    block_d         = block_q;
    o_miss_ready    = 1'b0;
    o_mem_req_valid = 1'b0;
    o_fill_valid    = 1'b0;
    word_en         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_miss_ready = 1'b1;
        if (i_miss_valid) begin
          addr_d  = i_miss_addr;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        o_mem_req_valid = 1'b1;
        // A flush after the request was accepted still owes us a response.
        if (i_flush)              state_d = i_mem_req_ready ? S_DRAIN : S_IDLE;
        else if (i_mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_flush) begin
          state_d = i_mem_rsp_valid ? S_IDLE : S_DRAIN;
        end else if (i_mem_rsp_valid) begin
          block_d = i_mem_rsp_data;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        // The block is good even if the core redirected, so the fill commits.
        o_fill_valid = 1'b1;
        word_en      = !i_flush;
        state_d      = (i_flush || i_word_ready) ? S_IDLE : S_DELIVER;
      end
      S_DELIVER: begin
        word_en = !i_flush;
        if (i_flush || i_word_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (i_mem_rsp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy         = (state_q != S_IDLE);
  assign o_mem_req_addr = {addr_q[ADDR_WIDTH-1:B_OFFSET_BITS], {B_OFFSET_BITS{1'b0}}};
  assign o_fill_index   = addr_q[INDEX_BITS+B_OFFSET_BITS-1:B_OFFSET_BITS];
  assign o_fill_tag     = addr_q[ADDR_WIDTH-1:INDEX_BITS+B_OFFSET_BITS];
  assign o_fill_data    = block_q;

  missed_word_driver #(
    .MEM_DATA_WIDTH (MEM_DATA_WIDTH),
    .WORD_WIDTH     (WORD_WIDTH),
    .B_OFFSET_BITS  (B_OFFSET_BITS)
  ) u_word_drv (
    .i_valid  (word_en),
    .i_block  (block_q),
    .i_offset (addr_q[B_OFFSET_BITS-1:0]),
    .o_valid  (o_word_valid),
    .o_word   (o_word)
  );

endmodule

// File: tb/tb_miss_refill_controller.sv
// Bench for miss_refill_controller: directed vector table, hand-written reset
// sequence, then randomized traffic against a transaction-level model.
module tb_miss_refill_controller;

  localparam int AW = 16, IB = 6, DW = 320, WW = 20, OB = 4, TW = AW - IB - OB;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_valid, mem_req_ready, mem_rsp_valid, word_ready, flush;
  logic [AW-1:0] miss_addr;
  logic [DW-1:0] rsp_data;
  logic          miss_ready, req_valid, fill_valid, word_valid, busy;
  logic [AW-1:0] req_addr;
  logic [IB-1:0] fill_index;
  logic [TW-1:0] fill_tag;
  logic [DW-1:0] fill_data;
  logic [WW-1:0] word;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  miss_refill_controller dut (
    .i_clk(clk), .i_rst(rst),
    .i_miss_valid(miss_valid), .i_miss_addr(miss_addr), .o_miss_ready(miss_ready),
    .o_mem_req_valid(req_valid), .o_mem_req_addr(req_addr), .i_mem_req_ready(mem_req_ready),
    .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rsp_data(rsp_data),
    .o_fill_valid(fill_valid), .o_fill_index(fill_index), .o_fill_tag(fill_tag),
    .o_fill_data(fill_data), .o_word_valid(word_valid), .o_word(word),
    .i_word_ready(word_ready), .i_flush(flush), .o_busy(busy)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {miss_ready, req_valid, fill_valid, word_valid, busy}
  function automatic logic [4:0] ctl();
    return {miss_ready, req_valid, fill_valid, word_valid, busy};
  endfunction

  // Directed block: word k = 0xC0000 | k*0x1111.
  function automatic logic [WW-1:0] wexp(input int k);
    return 20'hC0000 | WW'(k * 'h1111);
  endfunction

  typedef struct {
    logic          mv;
    logic [AW-1:0] ma;
    logic          rqr, rsv, wr, fl;
    logic [4:0]    ectl;
    logic          ca;
    logic [AW-1:0] ea;
    logic          cd;
    logic [IB-1:0] ei;
    logic [TW-1:0] et;
    logic [WW-1:0] ew;
  } vec_t;

  function automatic vec_t mk(input logic mv, input logic [AW-1:0] ma, input logic rqr,
                              input logic rsv, input logic wr, input logic fl,
                              input logic [4:0] ectl, input logic ca, input logic [AW-1:0] ea,
                              input logic cd, input logic [IB-1:0] ei, input logic [TW-1:0] et,
                              input logic [WW-1:0] ew);
    vec_t v;
    v.mv = mv; v.ma = ma; v.rqr = rqr; v.rsv = rsv; v.wr = wr; v.fl = fl;
    v.ectl = ectl; v.ca = ca; v.ea = ea; v.cd = cd; v.ei = ei; v.et = et; v.ew = ew;
    return v;
  endfunction

  localparam logic [4:0] C_IDLE = 5'b10000, C_REQ = 5'b01001, C_WAIT = 5'b00001,
                         C_FILL = 5'b00111, C_DLV = 5'b00011;

  logic [DW-1:0] blk_dir;
  vec_t          vq[$];

  // Reference model state (transaction view of the one outstanding miss).
  logic          m_act, m_drain, m_reqd, m_have, m_filled;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_blk;

  task automatic drive_idle();
    miss_valid = 0; miss_addr = '0; mem_req_ready = 0; mem_rsp_valid = 0;
    word_ready = 0; flush = 0;
  endtask

  initial begin
    logic [4:0]  ectl;
    logic [3:0]  k;
    drive_idle();
    rsp_data = '0;
    for (int j = 0; j < 16; j++) blk_dir[j*WW +: WW] = wexp(j);

    // Reset state
    rst = 1'b1;
    @(negedge clk); #1;
    chk("reset_ctl", DW'(ctl()), DW'(C_IDLE));
    chk("reset_fill_data", fill_data, '0);
    chk("reset_req_addr", DW'(req_addr), '0);
    @(negedge clk);
    rst = 1'b0;
    rsp_data = blk_dir;

    // Miss at 0x1A37, immediate ready/response, word consumed in FILL.
    vq.push_back(mk(1, 16'h1A37, 0, 0, 0, 0, C_IDLE, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, C_REQ, 1, 16'h1A30, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, C_WAIT, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, C_FILL, 1, 16'h1A30, 1, 6'h23, 6'h06, wexp(7)));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, C_IDLE, 0, 0, 0, 0, 0, 0));
    // Offset 15, core stalls 4 cycles: one fill, word held 5 cycles.
    vq.push_back(mk(1, 16'h0A5F, 0, 0, 0, 0, C_IDLE, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, C_REQ, 1, 16'h0A50, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, C_WAIT, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, C_FILL, 0, 0, 1, 6'h25, 6'h02, wexp(15)));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(0, 0, 0, 0, 0, 0, C_DLV, 0, 0, 1, 6'h25, 6'h02, wexp(15)));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, C_DLV, 0, 0, 1, 6'h25, 6'h02, wexp(15)));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, C_IDLE, 0, 0, 0, 0, 0, 0));
    // Memory not ready; flush on the third REQ cycle returns to IDLE.
    vq.push_back(mk(1, 16'h3C41, 0, 0, 0, 0, C_IDLE, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, C_REQ, 1, 16'h3C40, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, C_REQ, 1, 16'h3C40, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, C_REQ, 1, 16'h3C40, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, C_IDLE, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, C_IDLE, 0, 0, 0, 0, 0, 0));
    // Flush in WAIT, response 6 cycles later; a miss during DRAIN is ignored.
    vq.push_back(mk(1, 16'h0010, 0, 0, 0, 0, C_IDLE, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, C_REQ, 1, 16'h0010, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, C_WAIT, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 16'h7777, 0, 0, 0, 0, C_WAIT, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0, 0, 0, 0, 1, 0, C_WAIT, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, C_WAIT, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, C_IDLE, 1, 16'h0010, 0, 0, 0, 0));
    // Flush coincident with the response in WAIT.
    vq.push_back(mk(1, 16'h0020, 0, 0, 0, 0, C_IDLE, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, C_REQ, 1, 16'h0020, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, C_WAIT, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, C_IDLE, 0, 0, 0, 0, 0, 0));
    // Flush with request handshake in REQ must drain the response.
    vq.push_back(mk(1, 16'h0030, 0, 0, 0, 0, C_IDLE, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 1, C_REQ, 1, 16'h0030, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, C_WAIT, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, C_WAIT, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, C_IDLE, 0, 0, 0, 0, 0, 0));

    foreach (vq[i]) begin
      @(negedge clk);
      miss_valid = vq[i].mv; miss_addr = vq[i].ma; mem_req_ready = vq[i].rqr;
      mem_rsp_valid = vq[i].rsv; word_ready = vq[i].wr; flush = vq[i].fl;
      #1;
      chk($sformatf("v%0d_ctl", i), DW'(ctl()), DW'(vq[i].ectl));
      if (vq[i].ca) chk($sformatf("v%0d_req_addr", i), DW'(req_addr), DW'(vq[i].ea));
      if (vq[i].cd) begin
        chk($sformatf("v%0d_fill_index", i), DW'(fill_index), DW'(vq[i].ei));
        chk($sformatf("v%0d_fill_tag", i), DW'(fill_tag), DW'(vq[i].et));
        chk($sformatf("v%0d_word", i), DW'(word), DW'(vq[i].ew));
      end
    end

    // Reset asserted in DELIVER clears outputs without a clock edge.
    @(negedge clk); drive_idle(); miss_valid = 1; miss_addr = 16'h5555;
    @(negedge clk); drive_idle(); mem_req_ready = 1;
    @(negedge clk); drive_idle(); mem_rsp_valid = 1;
    @(negedge clk); drive_idle();
    @(negedge clk); #1;
    chk("rst_pre_ctl", DW'(ctl()), DW'(C_DLV));
    chk("rst_pre_word", DW'(word), DW'(wexp(5)));
    #1 rst = 1'b1;
    #1;
    chk("rst_async_ctl", DW'(ctl()), DW'(C_IDLE));
    chk("rst_async_data", fill_data, '0);
    @(negedge clk);
    rst = 1'b0; miss_valid = 1; miss_addr = 16'h1234;
    #1 chk("rst_after_ready", DW'(ctl()), DW'(C_IDLE));
    @(negedge clk); drive_idle();
    #1;
    chk("rst_after_req_ctl", DW'(ctl()), DW'(C_REQ));
    chk("rst_after_req_addr", DW'(req_addr), DW'(16'h1230));

    // Randomized traffic against the model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_act = 0; m_drain = 0; m_reqd = 0; m_have = 0; m_filled = 0; m_addr = '0; m_blk = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 99) == 0);
      miss_valid    = $urandom_range(0, 1);
      miss_addr     = AW'($urandom);
      mem_req_ready = ($urandom_range(0, 9) < 6);
      mem_rsp_valid = ($urandom_range(0, 9) < 4);
      word_ready    = $urandom_range(0, 1);
      flush         = ($urandom_range(0, 9) == 0);
      for (int w = 0; w < 10; w++) rsp_data[w*32 +: 32] = $urandom;
      #1;
      if (rst) begin
        m_act = 0; m_drain = 0; m_have = 0; m_filled = 0;
      end
      ectl = {!m_act && !m_drain, m_act && !m_reqd, m_act && m_have,
              m_act && (m_have || m_filled) && !flush, m_act || m_drain};
      chk($sformatf("r%0d_ctl", c), DW'(ctl()), DW'(ectl));
      if (ectl[3]) chk($sformatf("r%0d_req_addr", c), DW'(req_addr), DW'({m_addr[AW-1:OB], 4'h0}));
      if (ectl[2]) begin
        chk($sformatf("r%0d_fill_index", c), DW'(fill_index), DW'(m_addr[IB+OB-1:OB]));
        chk($sformatf("r%0d_fill_tag", c), DW'(fill_tag), DW'(m_addr[AW-1:IB+OB]));
        chk($sformatf("r%0d_fill_data", c), fill_data, m_blk);
      end
      if (ectl[1]) begin
        k = m_addr[3:0];
        chk($sformatf("r%0d_word", c), DW'(word), DW'(m_blk[int'(k)*WW +: WW]));
      end
      if (!rst) begin
        if (!m_act && !m_drain) begin
          if (miss_valid) begin
            m_act = 1; m_addr = miss_addr; m_reqd = 0; m_have = 0; m_filled = 0;
          end
        end else if (m_drain) begin
          if (mem_rsp_valid) m_drain = 0;
        end else if (!m_reqd) begin
          if (flush) begin m_act = 0; m_drain = mem_req_ready; end
          else if (mem_req_ready) m_reqd = 1;
        end else if (!m_have && !m_filled) begin
          if (flush) begin m_act = 0; m_drain = !mem_rsp_valid; end
          else if (mem_rsp_valid) begin m_have = 1; m_blk = rsp_data; end
        end else if (m_have) begin
          m_have = 0;
          if (flush || word_ready) m_act = 0;
          else m_filled = 1;
        end else begin
          if (flush || word_ready) begin m_act = 0; m_filled = 0; end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
